regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: alu_valid in 1, alu_addr in 4, alu_data in 32, forming the ALU writeback request channel.
REQ-004 SHALL have port: alu_ready  out  1  grant to the ALU channel; combinational.
REQ-005 SHALL have ports: mem_valid in 1, mem_addr in 4, mem_data in 32, forming the load writeback request channel.
REQ-006 SHALL have port: mem_ready  out  1  grant to the load channel; combinational.
REQ-007 SHALL have ports: reserve_en in 1, reserve_addr in 4, marking a destination register as pending at issue.
REQ-008 SHALL have ports: write_en out 1, addr_3 out 4, write_data out 32, registered and driving the register file write port.
REQ-009 SHALL have ports: pc_write_en out 1, pc_write_data out 32, registered, carrying writes to r15.
REQ-010 SHALL have port: busy  out  16  scoreboard; bit n set means register n has an outstanding writeback.

Function
REQ-011 SHALL define a transfer on a channel as valid=1 and ready=1 in the same cycle; the requester holds addr/data stable while valid=1 and ready=0.
REQ-012 SHALL grant at most one channel per cycle; a lone valid channel is granted immediately.
REQ-013 SHALL resolve simultaneous valid by round-robin: grant the channel not granted on the most recent conflict; update the pointer only on conflict cycles.
REQ-014 SHALL hold both ready outputs at 0 while rst=1.
REQ-015 SHALL, for a transfer with addr != 15, drive write_en=1, addr_3=addr, write_data=data in the next cycle, for exactly one cycle (latency 1).
REQ-016 SHALL, for a transfer with addr == 15, drive pc_write_en=1, pc_write_data=data in the next cycle, with write_en=0 that cycle.
REQ-017 SHALL drive write_en=0 and pc_write_en=0 in every cycle following a cycle with no transfer; addr_3/write_data/pc_write_data hold their last values.
REQ-018 SHALL set busy[reserve_addr] at the clock edge when reserve_en=1 and reserve_addr != 15; busy[15] is constant 0.
REQ-019 SHALL clear busy[addr_3] at the clock edge ending a cycle with write_en=1.
REQ-020 SHALL, on same-edge set and clear of the same register, leave the bit set (the new producer wins).
REQ-021 SHALL accept a reserve of an already-busy register with no change (no count, single pending bit).
REQ-022 SHALL permit writeback to a non-busy register; the write proceeds and busy stays 0.
REQ-023 SHALL sustain one writeback per cycle with back-to-back transfers and no bubble.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set write_en=0, addr_3=0, write_data=0, pc_write_en=0, pc_write_data=0, busy=16'h0000.
REQ-025 SHALL reset the round-robin pointer so the ALU channel wins the first conflict.
REQ-026 SHALL discard a transfer accepted in the cycle rst is asserted; no write follows.

Verification
REQ-027 Lone ALU: alu_valid=1, alu_addr=4'h0, alu_data=32'h000001DA -> alu_ready=1 same cycle; next cycle write_en=1, addr_3=0, write_data=32'h000001DA; following cycle write_en=0.
REQ-028 Conflict RR: both valid for 3 cycles (alu addr 1/32'h0000FFFF, mem addr A/32'h0A00D3F1), each dropping valid after its grant -> ALU granted cycle 1, MEM cycle 2; write_en pulses addr_3=1 then addr_3=A; next conflict grants MEM first.
REQ-029 Scoreboard: reserve_en=1, reserve_addr=4'h3 -> busy=16'h0008; mem write to r3 -> busy[3] clears the edge after write_en; same-edge reserve r3 during that write -> busy[3] stays 1.
REQ-030 PC redirect: alu_addr=4'hF, alu_data=32'h00000100 -> next cycle pc_write_en=1, pc_write_data=32'h00000100, write_en=0; reserve of r15 leaves busy=0.
REQ-031 Reset mid-operation: rst=1 while both valid and busy=16'h0402 -> readies 0, next cycle write_en=0, busy=0; after rst=0 with both valid, ALU granted first.
REQ-032 Streaming: mem_valid held 1 with addr 2,4,6 over 3 cycles -> write_en high 3 consecutive cycles, addr_3=2,4,6.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared by the ALU and load channels, the register-file write port and the busy scoreboard.
// The master drives the requests; the slave (the arbiter) grants them and drives the write ports.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        reserve_en;
    logic [3:0]  reserve_addr;
    logic        write_en;
    logic [3:0]  addr_3;
    logic [31:0] write_data;
    logic        pc_write_en;
    logic [31:0] pc_write_data;
    logic [15:0] busy;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output reserve_en, reserve_addr,
        input  alu_ready, mem_ready,
        input  write_en, addr_3, write_data,
        input  pc_write_en, pc_write_data, busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  reserve_en, reserve_addr,
        output alu_ready, mem_ready,
        output write_en, addr_3, write_data,
        output pc_write_en, pc_write_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-channel register-file writeback arbiter with round-robin conflict resolution,
// a one-cycle registered write port, r15 redirected to the PC port, and a pending-write scoreboard.
module regfile_wb_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    logic        rr_mem_q, rr_mem_d;
    logic        conflict, alu_gnt, mem_gnt, xfer;
    logic [3:0]  sel_addr;
    logic [31:0] sel_data;
    logic        write_en_q, write_en_d;
    logic [3:0]  addr_3_q, addr_3_d;
    logic [31:0] write_data_q, write_data_d;
    logic        pc_write_en_q, pc_write_en_d;
    logic [31:0] pc_write_data_q, pc_write_data_d;
    logic [15:0] busy_q, busy_d;

    always_comb begin
        conflict = bus.alu_valid & bus.mem_valid;
        // rr_mem_q set means the load channel wins the next conflict
        alu_gnt  = !rst & bus.alu_valid & (!bus.mem_valid | !rr_mem_q);
        mem_gnt  = !rst & bus.mem_valid & (!bus.alu_valid |  rr_mem_q);
        xfer     = alu_gnt | mem_gnt;
        sel_addr = mem_gnt ? bus.mem_addr : bus.alu_addr;
        sel_data = mem_gnt ? bus.mem_data : bus.alu_data;

        rr_mem_d = rr_mem_q;
        if (conflict) begin
            rr_mem_d = alu_gnt;
        end

        write_en_d      = xfer && (sel_addr != 4'hF);
        pc_write_en_d   = xfer && (sel_addr == 4'hF);
        addr_3_d        = addr_3_q;
        write_data_d    = write_data_q;
        pc_write_data_d = pc_write_data_q;
        if (write_en_d) begin
            addr_3_d     = sel_addr;
            write_data_d = sel_data;
        end
        if (pc_write_en_d) begin
            pc_write_data_d = sel_data;
        end

        // Set is applied after clear so a new producer reserving on the write edge keeps the bit
        busy_d = busy_q;
        if (write_en_q) begin
            busy_d[addr_3_q] = 1'b0;
        end
        if (bus.reserve_en && (bus.reserve_addr != 4'hF)) begin
            busy_d[bus.reserve_addr] = 1'b1;
        end
        busy_d[15] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_mem_q        <= 1'b0;
            write_en_q      <= 1'b0;
            addr_3_q        <= 4'h0;
            write_data_q    <= 32'h0;
            pc_write_en_q   <= 1'b0;
            pc_write_data_q <= 32'h0;
            busy_q          <= 16'h0000;
        end else begin
            rr_mem_q        <= rr_mem_d;
            write_en_q      <= write_en_d;
            addr_3_q        <= addr_3_d;
            write_data_q    <= write_data_d;
            pc_write_en_q   <= pc_write_en_d;
            pc_write_data_q <= pc_write_data_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.alu_ready     = alu_gnt;
    assign bus.mem_ready     = mem_gnt;
    assign bus.write_en      = write_en_q;
    assign bus.addr_3        = addr_3_q;
    assign bus.write_data    = write_data_q;
    assign bus.pc_write_en   = pc_write_en_q;
    assign bus.pc_write_data = pc_write_data_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// grants and busy checked against a behavioural model, writebacks checked by a monitor.
module tb_regfile_wb_arbiter;
    typedef struct {
        logic        pc;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];

    // behavioural model state
    logic [15:0] m_busy;
    logic        m_mem_pref;
    logic        m_wr_now;
    logic [3:0]  m_wr_addr;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented writeback must match the oldest expected one
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.write_en === 1'b1 || bus.pc_write_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", {bus.write_en, bus.pc_write_en}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_en", bus.write_en, !e.pc);
                    chk("pc_write_en", bus.pc_write_en, e.pc);
                    if (e.pc) begin
                        chk("pc_write_data", bus.pc_write_data, e.data);
                    end else begin
                        chk("addr_3", bus.addr_3, e.addr);
                        chk("write_data", bus.write_data, e.data);
                    end
                end
            end
        end
    end

    // One bus cycle: drive inputs, check grants and busy at the falling edge, advance the model.
    task automatic cycle(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic re, input logic [3:0] ra, input logic r,
                         output logic ag, output logic mg);
        wr_t w;
        rst              = r;
        bus.alu_valid    = av;
        bus.alu_addr     = aa;
        bus.alu_data     = ad;
        bus.mem_valid    = mv;
        bus.mem_addr     = ma;
        bus.mem_data     = md;
        bus.reserve_en   = re;
        bus.reserve_addr = ra;
        @(negedge clk);
        ag = 1'b0;
        mg = 1'b0;
        if (!r) begin
            if (av && mv) begin
                if (m_mem_pref) mg = 1'b1;
                else            ag = 1'b1;
                m_mem_pref = ag;
            end else begin
                ag = av;
                mg = mv;
            end
        end
        chk("alu_ready", bus.alu_ready, ag);
        chk("mem_ready", bus.mem_ready, mg);
        chk("busy", bus.busy, m_busy);
        if (ag || mg) begin
            w.addr = mg ? ma : aa;
            w.data = mg ? md : ad;
            w.pc   = (w.addr == 4'hF);
            exp_q.push_back(w);
        end
        if (r) begin
            m_busy     = 16'h0000;
            m_mem_pref = 1'b0;
            m_wr_now   = 1'b0;
        end else begin
            if (m_wr_now) m_busy[m_wr_addr] = 1'b0;
            if (re && ra != 4'hF) m_busy[ra] = 1'b1;
            m_wr_now  = (ag || mg) && ((mg ? ma : aa) != 4'hF);
            m_wr_addr = mg ? ma : aa;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic re, input logic [3:0] ra);
        logic ag, mg;
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, re, ra, 1'b0, ag, mg);
    endtask

    task automatic alu(input logic [3:0] a, input logic [31:0] d);
        logic ag, mg;
        cycle(1'b1, a, d, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, ag, mg);
    endtask

    task automatic mem(input logic [3:0] a, input logic [31:0] d);
        logic ag, mg;
        cycle(1'b0, 4'h0, 32'h0, 1'b1, a, d, 1'b0, 4'h0, 1'b0, ag, mg);
    endtask

    initial begin
        logic        ag, mg;
        logic        a_pend, m_pend;
        logic [3:0]  a_addr, m_addr;
        logic [31:0] a_data, m_data;

        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_addr = 4'h0; bus.alu_data = 32'h0;
        bus.mem_valid = 1'b0; bus.mem_addr = 4'h0; bus.mem_data = 32'h0;
        bus.reserve_en = 1'b0; bus.reserve_addr = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_write_en", bus.write_en, 1'b0);
        chk("rst_addr_3", bus.addr_3, 4'h0);
        chk("rst_write_data", bus.write_data, 32'h0);
        chk("rst_pc_write_en", bus.pc_write_en, 1'b0);
        chk("rst_pc_write_data", bus.pc_write_data, 32'h0);
        chk("rst_busy", bus.busy, 16'h0000);
        m_busy = 16'h0000; m_mem_pref = 1'b0; m_wr_now = 1'b0; m_wr_addr = 4'h0;

        // lone ALU
        alu(4'h0, 32'h000001DA);
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);
        // conflict round-robin, then next conflict goes to MEM
        cycle(1'b1, 4'h1, 32'h0000FFFF, 1'b1, 4'hA, 32'h0A00D3F1, 1'b0, 4'h0, 1'b0, ag, mg);
        mem(4'hA, 32'h0A00D3F1);
        idle(1'b0, 4'h0);
        cycle(1'b1, 4'h2, 32'h11111111, 1'b1, 4'h5, 32'h22222222, 1'b0, 4'h0, 1'b0, ag, mg);
        alu(4'h2, 32'h11111111);
        idle(1'b0, 4'h0);
        // scoreboard set/clear and same-edge reserve
        idle(1'b1, 4'h3);
        mem(4'h3, 32'h33333333);
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);
        idle(1'b1, 4'h3);
        mem(4'h3, 32'h44444444);
        idle(1'b1, 4'h3);
        idle(1'b0, 4'h0);
        chk("same_edge_busy3", bus.busy, 16'h0008);
        // PC redirect and r15 reserve
        cycle(1'b1, 4'hF, 32'h00000100, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 1'b0, ag, mg);
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);
        // reset mid-operation with busy = 16'h0402
        mem(4'h3, 32'h55555555);
        idle(1'b1, 4'h1);
        idle(1'b1, 4'hA);
        cycle(1'b1, 4'h6, 32'h66666666, 1'b1, 4'h7, 32'h77777777, 1'b0, 4'h0, 1'b1, ag, mg);
        cycle(1'b1, 4'h6, 32'h66666666, 1'b1, 4'h7, 32'h77777777, 1'b0, 4'h0, 1'b0, ag, mg);
        mem(4'h7, 32'h77777777);
        idle(1'b0, 4'h0);
        // streaming loads
        mem(4'h2, 32'h00000002);
        mem(4'h4, 32'h00000004);
        mem(4'h6, 32'h00000006);
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);

        // randomized traffic; requesters hold addr/data until granted
        a_pend = 1'b0; m_pend = 1'b0;
        a_addr = 4'h0; m_addr = 4'h0; a_data = 32'h0; m_data = 32'h0;
        for (int i = 0; i < 800; i++) begin
            if (!a_pend && ($urandom_range(2) != 0)) begin
                a_pend = 1'b1; a_addr = 4'($urandom_range(15)); a_data = $urandom;
            end
            if (!m_pend && ($urandom_range(2) != 0)) begin
                m_pend = 1'b1; m_addr = 4'($urandom_range(15)); m_data = $urandom;
            end
            cycle(a_pend, a_addr, a_data, m_pend, m_addr, m_data,
                  ($urandom_range(2) == 0), 4'($urandom_range(15)),
                  ($urandom_range(40) == 0), ag, mg);
            if (ag) a_pend = 1'b0;
            if (mg) m_pend = 1'b0;
        end
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);
        idle(1'b0, 4'h0);
        chk("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
